// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction loader: FSM states and
// the byte geometry of the length header and of each instruction word.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage : uart_loader_pkg

// File: rtl/byte_word_packer.sv
// Big-endian byte-to-word packer: shifts accepted bytes in MSB first and flags
// the cycle on which the fourth byte completes a word (word is valid then).
module byte_word_packer
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [23:0] sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;

  // The completed word includes the byte arriving this cycle, so the top can
  // register it with a single cycle of latency.
  assign word_ready = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {sr_q, byte_in};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      sr_d  = {sr_q[15:0], byte_in};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: the shift register is reset (not left as storage) so a load cut short never leaks stale bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule : byte_word_packer

// File: rtl/uart_inst_loader.sv
// Parses a length-prefixed program image from the UART byte stream and writes
// it to instruction memory. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module uart_inst_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [ADDR_W-1:0] uart_addr,
  output logic              uart_wr_en,
  output logic [31:0]       uart_wdata,
  output logic              recv_done,
  output logic              load_err,
  output logic              busy
);

  if (MAX_WORDS < 1 || MAX_WORDS > 65535 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_inst_loader: MAX_WORDS must be 1..65535 and TIMEOUT_CYCLES at least 2");
  end

  state_e              state_q, state_d;
  logic [15:0]         hdr_q, hdr_d;
  logic                hdr_idx_q, hdr_idx_d;
  logic [15:0]         word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                recv_done_q, recv_done_d;
  logic                load_err_q, load_err_d;
  logic                busy_q, busy_d;

  logic                pk_clear, pk_accept, pk_word_ready;
  logic [31:0]         pk_word;
  logic [15:0]         hdr_n;
  logic                timeout;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (pk_clear),
    .accept     (pk_accept),
    .byte_in    (rx_byte),
    .word_ready (pk_word_ready),
    .word       (pk_word)
  );

  assign hdr_n = {hdr_q[15:8], rx_byte};

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d  = '0;
    timeout = 1'b0;
    if (state_q == HDR || state_q == DATA) begin
      if (!rx_valid) begin
        if (idle_q == TMO_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
        else                                      idle_d  = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdr_idx_d   = hdr_idx_q;
    word_cnt_d  = word_cnt_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wdata_d     = wdata_q;
    recv_done_d = recv_done_q;
    load_err_d  = load_err_q;
    pk_clear    = 1'b0;
    pk_accept   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // recv_done follows the DONE state one cycle later, after the final write.
        if (state_q == DONE) recv_done_d = 1'b1;
        if (load_start) begin
          state_d     = HDR;
          recv_done_d = 1'b0;
          load_err_d  = 1'b0;
          hdr_idx_d   = 1'b0;
          word_cnt_d  = '0;
          pk_clear    = 1'b1;
        end
      end
      HDR: begin
        if (rx_valid) begin
          if (hdr_idx_q != 1'(HDR_BYTES - 1)) begin
            hdr_d[15:8] = rx_byte;
            hdr_idx_d   = 1'b1;
          end else begin
            hdr_d[7:0] = rx_byte;
            hdr_idx_d  = 1'b0;
            if (hdr_n == 16'd0) begin
              state_d = DONE;
            end else if (32'(hdr_n) > MAX_WORDS) begin
              load_err_d = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        pk_accept = rx_valid;
        if (pk_word_ready) begin
          wr_en_d    = 1'b1;
          wdata_d    = pk_word;
          addr_d     = ADDR_W'(word_cnt_q);
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_q == hdr_q - 16'd1) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d    = IDLE;
      load_err_d = 1'b1;
      pk_clear   = 1'b1;
    end

    busy_d = (state_d == HDR) || (state_d == DATA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      hdr_idx_q   <= 1'b0;
      word_cnt_q  <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wdata_q     <= '0;
      recv_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_idx_q   <= hdr_idx_d;
      word_cnt_q  <= word_cnt_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wdata_q     <= wdata_d;
      recv_done_q <= recv_done_d;
      load_err_q  <= load_err_d;
      busy_q      <= busy_d;
    end
  end

  assign uart_addr  = addr_q;
  assign uart_wr_en = wr_en_q;
  assign uart_wdata = wdata_q;
  assign recv_done  = recv_done_q;
  assign load_err   = load_err_q;
  assign busy       = busy_q;

endmodule : uart_inst_loader

// File: tb/tb_uart_inst_loader.sv
// Scoreboard bench for uart_inst_loader: expected writes are queued as bytes
// are driven and popped by a write monitor on the falling edge.
module tb_uart_inst_loader;

  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic [ADDR_W-1:0] uart_addr;
  logic              uart_wr_en;
  logic [31:0]       uart_wdata;
  logic              recv_done;
  logic              load_err;
  logic              busy;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_wr_t;

  exp_wr_t sb[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      n_wr  = 0;

  uart_inst_loader #(
    .ADDR_W         (ADDR_W),
    .MAX_WORDS      (256),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .load_start (load_start),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .uart_addr  (uart_addr),
    .uart_wr_en (uart_wr_en),
    .uart_wdata (uart_wdata),
    .recv_done  (recv_done),
    .load_err   (load_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && uart_wr_en) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(uart_addr), 64'hFFFF_FFFF);
      end else begin
        exp_wr_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(uart_addr), 64'(e.addr));
        check("wr_data", 64'(uart_wdata), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] addr, input logic [31:0] data);
    exp_wr_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(data[31-8*i -: 8]);
  endtask

  function automatic logic [51:0] outs();
    return {uart_addr, uart_wdata, uart_wr_en, recv_done, load_err, busy};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'(outs()), 64'h0);
    rst_n = 1'b1;
    tick();

    // Two-word image, back-to-back bytes.
    pulse_start();
    check("busy_after_start", 64'(busy), 64'h1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(16'd0, 32'h2408_0005);
    send_word(16'd1, 32'hAC08_0000);
    check("last_wr_en", 64'(uart_wr_en), 64'h1);
    check("done_not_yet", 64'(recv_done), 64'h0);
    tick();
    check("recv_done", 64'(recv_done), 64'h1);
    check("idle_after_done", 64'(busy), 64'h0);
    send_byte(8'h55);
    tick();
    check("done_holds", 64'(recv_done), 64'h1);
    check("wdata_holds", 64'(uart_wdata), 64'hAC08_0000);

    // Empty image.
    pulse_start();
    check("start_clears_done", 64'(recv_done), 64'h0);
    send_byte(8'h00);
    send_byte(8'h00);
    tick();
    check("empty_done", 64'(recv_done), 64'h1);

    // Oversize header, then a fresh start clears the error.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    check("oversize_err", 64'(load_err), 64'h1);
    check("oversize_idle", 64'(busy), 64'h0);
    send_byte(8'h77);
    pulse_start();
    check("start_clears_err", 64'(load_err), 64'h0);

    // Maximum count accepted, then reset lands mid-word.
    send_byte(8'h01);
    send_byte(8'h00);
    check("max_count_ok", 64'({load_err, busy}), 64'h1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    check("reset_mid_load", 64'(outs()), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(16'd0, 32'h1234_5678);
    tick();
    check("fresh_load_done", 64'(recv_done), 64'h1);

    // Six consecutive bytes with a stray start pulse mid-stream.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    sb.push_back('{addr: 16'd0, data: 32'hDEAD_BEEF});
    send_byte(8'hDE);
    load_start = 1'b1;
    send_byte(8'hAD);
    load_start = 1'b0;
    send_byte(8'hBE);
    send_byte(8'hEF);
    tick();
    check("midstream_start_ignored", 64'(recv_done), 64'h1);

    // Start and a byte together in DONE: the byte must be dropped.
    load_start = 1'b1;
    rx_valid   = 1'b1;
    rx_byte    = 8'h00;
    tick();
    load_start = 1'b0;
    rx_valid   = 1'b0;
    check("start_with_byte", 64'({busy, recv_done}), 64'h2);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(16'd0, 32'hCAFE_F00D);
    tick();
    check("dropped_byte_done", 64'(recv_done), 64'h1);

    // Stall mid-word.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
`ifdef LOADER_TIMEOUT_EN
    repeat (49) tick();
    check("pre_timeout_busy", 64'({load_err, busy}), 64'h1);
    tick();
    check("timeout_err", 64'({load_err, busy}), 64'h2);
`else
    repeat (1000) tick();
    check("no_timeout_busy", 64'({load_err, busy}), 64'h1);
`endif

    tick();
    check("sb_drain", 64'(sb.size()), 64'h0);
    check("write_count", 64'(n_wr), 64'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_inst_loader

// File: doc/uart_inst_loader.md
Name: uart_inst_loader

Overview:
Upstream feeder for the CPU instruction memory. It consumes the byte stream from the UART receiver and parses a length-prefixed program image. It assembles big-endian 32-bit words and issues single-cycle writes on the instruction-memory load port (addr / wr_en / wdata / recv_done). It runs in the system clock domain alongside the UART receiver.

Parameters:
- ADDR_W, 16: width of word address on write port.
- MAX_WORDS, 256: instruction memory depth in words; larger header counts flag an error.
- TIMEOUT_CYCLES, 1000000: inter-byte idle limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; arms a new load.
- rx_valid  in  1  one-cycle strobe from UART receiver, byte valid.
- rx_byte  in  8  received byte, qualified by rx_valid.
- uart_addr  out  ADDR_W  word address of current write.
- uart_wr_en  out  1  one-cycle write strobe to instruction memory.
- uart_wdata  out  32  assembled instruction word.
- recv_done  out  1  high when the image is fully written; held until the next load_start.
- load_err  out  1  high on oversize header or timeout; held until the next load_start.
- busy  out  1  high in HDR or DATA.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. All of the following clear to 0: uart_addr, uart_wr_en, uart_wdata, recv_done, load_err, busy, byte counter, word counter and header register. A partially assembled word is discarded. Reset takes effect immediately, including mid-load.
- State IDLE: rx_valid is ignored. On load_start go to HDR, clear recv_done and load_err, and clear both counters.
- State HDR: take 2 bytes, big-endian (first byte goes to hdr[15:8]), into the 16-bit word count N. On the 2nd byte:
  - N==0: go to DONE.
  - N>MAX_WORDS: set load_err and go to IDLE.
  - Otherwise: go to DATA.
- State DATA:
  - Shift each byte in, MSB first (byte 0 goes to [31:24]). A 2-bit byte counter wraps 3→0.
  - When the 4th byte of a word is accepted, the next cycle shows uart_wr_en=1 for exactly one cycle. On that same cycle uart_wdata is the full word and uart_addr is the word index (0-based).
  - The word index increments after each write.
  - When the write of word N-1 is issued, go to DONE.
- State DONE: recv_done=1 and rx_valid is ignored. load_start returns to HDR, clearing recv_done.
- load_start while busy: ignored; the load in progress continues.
- rx_valid and load_start asserted together in IDLE/DONE: the byte is dropped and only the start is taken.
- Latency: 1 clk from the rx_valid of a word's last byte to uart_wr_en. Back-to-back rx_valid on consecutive cycles must be accepted with no byte loss.
- uart_addr and uart_wdata hold their last values between writes.
- busy = (state==HDR || state==DATA), driven from a register.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- With the macro defined:
  - An idle counter runs in HDR/DATA and resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1: set load_err, go to IDLE, discard the partial word. Words already written remain in memory.
  - The counter is held at 0 outside HDR/DATA.
- Without the macro: no counter logic exists, and HDR/DATA wait indefinitely.

Decomposition:
- Shared package (uart_loader_pkg): state enum (IDLE, HDR, DATA, DONE), HDR_BYTES=2, BYTES_PER_WORD=4.
- One natural sub-module: byte_word_packer. It contains the shift register and the 2-bit byte counter, with outputs word_ready and word.
- The FSM, counters and timeout stay in the top module.

Test Plan:
- Header 00 02, then bytes 24 08 00 05 / AC 08 00 00 → uart_wr_en pulses twice: addr 0 wdata 0x24080005, then addr 1 wdata 0xAC080000. recv_done rises on the cycle after the 2nd write.
- Header 00 00 → no writes; recv_done=1 after the 2nd header byte.
- Header 01 01 (257 > 256) → load_err=1, state IDLE, no writes. A following load_start clears load_err.
- Assert reset after 2 of 4 bytes of word 0 → all outputs 0. A fresh load then writes addr 0 correctly with no stale bytes.
- Apply rx_valid on 6 consecutive cycles (header 00 01 + 4 data bytes) → exactly one write of the correct word. A load_start pulse mid-stream is ignored.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=50: header 00 01 plus 2 bytes, then idle 50 cycles → load_err=1, IDLE, no write. Without the macro the block is still busy after 1000 idle cycles.
